// File: rtl/board_ctrl.sv
// rtl/board_ctrl.sv - 8x8 game-board controller: frame-synchronised commands and registered pixel lookup
module board_ctrl #(
  parameter int N     = 8,
  parameter int CELL  = 56,
  parameter int FRAME = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       btn_left,
  input  logic       btn_right,
  input  logic       btn_place,
  input  logic       frame_tick,
  input  logic [9:0] x,
  input  logic [9:0] y,
  output logic       in_cell,
  output logic [1:0] cell_state,
  output logic       is_cursor,
  output logic       player,
  output logic       busy,
  output logic       reject,
  output logic       done
);

  localparam logic [9:0] PITCH = 10'(CELL + FRAME);

  typedef enum logic [1:0] {IDLE, WAIT_FRAME, APPLY, DONE} state_t;

  localparam logic [2:0] CMD_UP    = 3'd0;
  localparam logic [2:0] CMD_DOWN  = 3'd1;
  localparam logic [2:0] CMD_LEFT  = 3'd2;
  localparam logic [2:0] CMD_RIGHT = 3'd3;
  localparam logic [2:0] CMD_PLACE = 3'd4;

  state_t     state, state_next;
  logic [1:0] board [64];
  logic [2:0] cur_col, cur_row;
  logic [6:0] occ_count;
  logic [2:0] cmd, cmd_sel;
  logic       any_btn, place_ok;
  logic [5:0] cur_idx;

  assign any_btn = btn_up | btn_down | btn_left | btn_right | btn_place;
  assign cur_idx = {cur_row, cur_col};
  assign place_ok = (cmd == CMD_PLACE) && (board[cur_idx] == 2'b00);
  assign busy = (state == WAIT_FRAME) || (state == APPLY);
  assign done = (state == DONE);

  always_comb begin
    cmd_sel = CMD_RIGHT;
    if (btn_place)     cmd_sel = CMD_PLACE;
    else if (btn_up)   cmd_sel = CMD_UP;
    else if (btn_down) cmd_sel = CMD_DOWN;
    else if (btn_left) cmd_sel = CMD_LEFT;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // A full board can only be reached by a successful place at count 63.
  always_comb begin
    state_next = state;
    case (state)
      IDLE, DONE: if (any_btn) state_next = WAIT_FRAME;
      WAIT_FRAME: if (frame_tick) state_next = APPLY;
      APPLY: begin
        if ((occ_count == 7'd64) || (place_ok && occ_count == 7'd63)) state_next = DONE;
        else state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 64; i++) board[i] <= 2'b00;
      cur_col   <= 3'd0;
      cur_row   <= 3'd0;
      player    <= 1'b0;
      occ_count <= 7'd0;
      cmd       <= 3'd0;
      reject    <= 1'b0;
    end else begin
      reject <= 1'b0;
      if ((state == IDLE || state == DONE) && any_btn) cmd <= cmd_sel;
      if (state == APPLY) begin
        case (cmd)
          CMD_UP:    cur_row <= cur_row - 3'd1;
          CMD_DOWN:  cur_row <= cur_row + 3'd1;
          CMD_LEFT:  cur_col <= cur_col - 3'd1;
          CMD_RIGHT: cur_col <= cur_col + 3'd1;
          default: begin
            if (place_ok) begin
              board[cur_idx] <= player ? 2'b10 : 2'b01;
              player         <= ~player;
              occ_count      <= occ_count + 7'd1;
            end else begin
              reject <= 1'b1;
            end
          end
        endcase
      end
    end
  end

  logic [9:0] col, row, xo, yo;
  logic       in_cell_c;

  assign col = x / PITCH;
  assign row = y / PITCH;
  assign xo  = x % PITCH;
  assign yo  = y % PITCH;
  assign in_cell_c = (col < 10'(N)) && (row < 10'(N)) && (xo < 10'(CELL)) && (yo < 10'(CELL));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      in_cell    <= 1'b0;
      cell_state <= 2'b00;
      is_cursor  <= 1'b0;
    end else begin
      in_cell    <= in_cell_c;
      cell_state <= in_cell_c ? board[{row[2:0], col[2:0]}] : 2'b00;
      is_cursor  <= in_cell_c && (col[2:0] == cur_col) && (row[2:0] == cur_row);
    end
  end

endmodule

// File: tb/tb_board_ctrl.sv
// tb/tb_board_ctrl.sv - randomized self-checking bench for board_ctrl against a cell/cursor model
module tb_board_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] btns;  // {place, up, down, left, right}
  logic       frame_tick;
  logic [9:0] x, y;
  logic       in_cell, is_cursor, player, busy, reject, done;
  logic [1:0] cell_state;

  board_ctrl dut (
    .clk(clk), .rst(rst),
    .btn_up(btns[3]), .btn_down(btns[2]), .btn_left(btns[1]), .btn_right(btns[0]),
    .btn_place(btns[4]), .frame_tick(frame_tick), .x(x), .y(y),
    .in_cell(in_cell), .cell_state(cell_state), .is_cursor(is_cursor),
    .player(player), .busy(busy), .reject(reject), .done(done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  int m_board[64];
  int m_col, m_row, m_player, m_count;

  function automatic void m_reset();
    for (int i = 0; i < 64; i++) m_board[i] = 0;
    m_col = 0; m_row = 0; m_player = 0; m_count = 0;
  endfunction

  function automatic int m_apply(input logic [4:0] b);
    int idx;
    if (b[4]) begin
      idx = m_row * 8 + m_col;
      if (m_count == 64 || m_board[idx] != 0) return 1;
      m_board[idx] = m_player + 1;
      m_player = 1 - m_player;
      m_count++;
    end else if (b[3]) m_row = (m_row + 7) % 8;
    else if (b[2]) m_row = (m_row + 1) % 8;
    else if (b[1]) m_col = (m_col + 7) % 8;
    else if (b[0]) m_col = (m_col + 1) % 8;
    return 0;
  endfunction

  function automatic void exp_look(input int xx, input int yy, output bit ic, output int st, output bit cu);
    int c, r;
    c = xx / 60; r = yy / 60;
    ic = (c < 8) && (r < 8) && (xx % 60 < 56) && (yy % 60 < 56);
    st = ic ? m_board[r * 8 + c] : 0;
    cu = ic && (c == m_col) && (r == m_row);
  endfunction

  task automatic do_reset();
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    m_reset();
  endtask

  // Issue one command; busy_b is pressed during the first busy cycle and must be lost.
  task automatic do_cmd(input logic [4:0] b, input logic [4:0] busy_b, input bit same_tick, input int gap,
                        output bit bz1, output bit bz2, output bit bz3, output bit rj, output bit rj2,
                        output bit dn);
    @(negedge clk); btns = b; frame_tick = same_tick;
    @(negedge clk); btns = busy_b; frame_tick = 1'b0; bz1 = busy;
    @(negedge clk); btns = 5'b0;
    repeat (gap) @(negedge clk);
    frame_tick = 1'b1;
    @(negedge clk); frame_tick = 1'b0; bz2 = busy;
    @(negedge clk); bz3 = busy; rj = reject; dn = done;
    @(negedge clk); rj2 = reject;
  endtask

  task automatic probe(input int c, input int r, output bit ic, output int st, output bit cu);
    @(negedge clk); x = 10'(c * 60 + 30); y = 10'(r * 60 + 30);
    @(negedge clk); ic = in_cell; st = int'(cell_state); cu = is_cursor;
  endtask

  task automatic test_reset();
    btns = 5'b0; frame_tick = 1'b0; x = 10'd30; y = 10'd30; rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (in_cell !== 1'b0) begin errors++; $display("FAIL reset_in_cell got %b exp 0", in_cell); end
    checks++; if (is_cursor !== 1'b0) begin errors++; $display("FAIL reset_is_cursor got %b exp 0", is_cursor); end
    checks++; if ({player, busy, reject, done, cell_state} !== 6'b0) begin
      errors++; $display("FAIL reset_outputs got %b exp 000000", {player, busy, reject, done, cell_state}); end
    rst = 1'b0; m_reset();
  endtask

  task automatic test_reset_mid_wait();
    bit ic, cu; int st;
    @(negedge clk); btns = 5'b00001;
    @(negedge clk); btns = 5'b0;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL midwait_busy got %b exp 1", busy); end
    rst = 1'b1; #1;
    checks++; if ({busy, player, reject, done} !== 4'b0) begin
      errors++; $display("FAIL midwait_rst_outputs got %b exp 0000", {busy, player, reject, done}); end
    @(negedge clk); rst = 1'b0; m_reset();
    frame_tick = 1'b1;
    @(negedge clk); frame_tick = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midwait_busy_after got %b exp 0", busy); end
    probe(0, 0, ic, st, cu);
    checks++; if (cu !== 1'b1) begin errors++; $display("FAIL midwait_cursor00 got %b exp 1", cu); end
    probe(1, 0, ic, st, cu);
    checks++; if (cu !== 1'b0) begin errors++; $display("FAIL midwait_cursor10 got %b exp 0", cu); end
  endtask

  task automatic test_wrap();
    bit b1, b2, b3, rj, rj2, dn, ic, cu; int st;
    do_cmd(5'b00010, 5'b0, 1'b0, 2, b1, b2, b3, rj, rj2, dn); void'(m_apply(5'b00010));
    checks++; if ({b1, b2, b3, rj} !== 4'b1100) begin
      errors++; $display("FAIL wrap_left_timing got %b exp 1100", {b1, b2, b3, rj}); end
    probe(7, 0, ic, st, cu);
    checks++; if (cu !== 1'b1 || m_col != 7) begin errors++; $display("FAIL wrap_left_cursor got %b exp 1", cu); end
    do_cmd(5'b01000, 5'b0, 1'b1, 0, b1, b2, b3, rj, rj2, dn); void'(m_apply(5'b01000));
    probe(7, 7, ic, st, cu);
    checks++; if (cu !== 1'b1) begin errors++; $display("FAIL wrap_up_cursor got %b exp 1", cu); end
    do_cmd(5'b00001, 5'b0, 1'b0, 0, b1, b2, b3, rj, rj2, dn); void'(m_apply(5'b00001));
    do_cmd(5'b00100, 5'b0, 1'b0, 1, b1, b2, b3, rj, rj2, dn); void'(m_apply(5'b00100));
    probe(0, 0, ic, st, cu);
    checks++; if (cu !== 1'b1) begin errors++; $display("FAIL wrap_back_cursor got %b exp 1", cu); end
  endtask

  task automatic test_place();
    bit b1, b2, b3, rj, rj2, dn, ic, cu; int st;
    do_cmd(5'b10000, 5'b0, 1'b0, 0, b1, b2, b3, rj, rj2, dn); void'(m_apply(5'b10000));
    checks++; if (rj !== 1'b0 || player !== 1'b1) begin
      errors++; $display("FAIL place_first got rej=%b player=%b exp rej=0 player=1", rj, player); end
    probe(0, 0, ic, st, cu);
    checks++; if (st != 1) begin errors++; $display("FAIL place_cell got %0d exp 1", st); end
    do_cmd(5'b10000, 5'b0, 1'b0, 1, b1, b2, b3, rj, rj2, dn);
    checks++; if ({rj, rj2} !== {1'(m_apply(5'b10000)), 1'b0}) begin
      errors++; $display("FAIL place_reject_pulse got %b exp 10", {rj, rj2}); end
    checks++; if (player !== 1'(m_player)) begin errors++; $display("FAIL place_reject_player got %b exp %0d", player, m_player); end
  endtask

  task automatic test_priority_drop();
    bit b1, b2, b3, rj, rj2, dn, ic, cu; int st;
    do_cmd(5'b00001, 5'b00100, 1'b0, 0, b1, b2, b3, rj, rj2, dn); void'(m_apply(5'b00001));
    probe(1, 0, ic, st, cu);
    checks++; if (cu !== 1'b1) begin errors++; $display("FAIL drop_busy_down got cursor %b exp 1", cu); end
    do_cmd(5'b10001, 5'b0, 1'b0, 0, b1, b2, b3, rj, rj2, dn); void'(m_apply(5'b10001));
    probe(1, 0, ic, st, cu);
    checks++; if (cu !== 1'b1 || st != m_board[1]) begin
      errors++; $display("FAIL priority_place got cursor=%b cell=%0d exp cursor=1 cell=%0d", cu, st, m_board[1]); end
  endtask

  task automatic test_lookup();
    int xs[12] = '{30, 57, 60, 89, 479, 480, 0, 55, 56, 59, 1023, 419};
    bit e_ic, e_cu; int e_st;
    for (int i = 0; i <= 60; i++) begin
      @(negedge clk);
      if (i > 0) begin
        checks++;
        if ({in_cell, cell_state, is_cursor} !== {e_ic, 2'(e_st), e_cu}) begin
          errors++; $display("FAIL lookup x=%0d y=%0d got %b exp %b", x, y,
                             {in_cell, cell_state, is_cursor}, {e_ic, 2'(e_st), e_cu}); end
      end
      if (i < 12) begin x = 10'(xs[i]); y = 10'(xs[(i + 5) % 12]); end
      else begin x = 10'($urandom_range(0, 1023)); y = 10'($urandom_range(0, 520)); end
      exp_look(int'(x), int'(y), e_ic, e_st, e_cu);
    end
  endtask

  task automatic test_random_cmds();
    bit b1, b2, b3, rj, rj2, dn, ic, cu; int st, e;
    logic [4:0] b;
    do_reset();
    for (int i = 0; i < 80; i++) begin
      b = 5'($urandom_range(1, 31));
      if ($urandom_range(0, 2) == 0) b = 5'b10000;
      do_cmd(b, 5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)), $urandom_range(0, 3), b1, b2, b3, rj, rj2, dn);
      e = m_apply(b);
      checks++;
      if ({b1, b2, b3, rj, rj2, player} !== {3'b110, 1'(e), 1'b0, 1'(m_player)}) begin
        errors++; $display("FAIL random_cmd%0d got %b exp %b", i, {b1, b2, b3, rj, rj2, player},
                           {3'b110, 1'(e), 1'b0, 1'(m_player)}); end
    end
    for (int c = 0; c < 64; c++) begin
      probe(c % 8, c / 8, ic, st, cu);
      checks++;
      if (st != m_board[c] || cu !== ((c % 8) == m_col && (c / 8) == m_row)) begin
        errors++; $display("FAIL random_board cell%0d got %0d/%b exp %0d", c, st, cu, m_board[c]); end
    end
  endtask

  task automatic test_full_board();
    bit b1, b2, b3, rj, rj2, dn, ic, cu; int st;
    do_reset();
    for (int r = 0; r < 8; r++) begin
      for (int c = 0; c < 8; c++) begin
        do_cmd(5'b10000, 5'b0, 1'b0, 0, b1, b2, b3, rj, rj2, dn); void'(m_apply(5'b10000));
        checks++;
        if ({rj, dn} !== {1'b0, 1'(m_count == 64)}) begin
          errors++; $display("FAIL full_place r%0d c%0d got rej/done %b exp 0%b", r, c, {rj, dn}, m_count == 64); end
        if (m_count < 64) begin
          do_cmd(5'b00001, 5'b0, 1'b0, 0, b1, b2, b3, rj, rj2, dn); void'(m_apply(5'b00001));
          if (c == 7) begin
            do_cmd(5'b00100, 5'b0, 1'b0, 0, b1, b2, b3, rj, rj2, dn); void'(m_apply(5'b00100));
          end
        end
      end
    end
    checks++; if (done !== 1'b1 || player !== 1'b0) begin
      errors++; $display("FAIL full_done got done=%b player=%b exp 1 0", done, player); end
    do_cmd(5'b10000, 5'b0, 1'b0, 1, b1, b2, b3, rj, rj2, dn);
    checks++; if ({rj, rj2, dn, b1} !== {1'(m_apply(5'b10000)), 1'b0, 1'b1, 1'b1}) begin
      errors++; $display("FAIL full_place_reject got %b exp 1011", {rj, rj2, dn, b1}); end
    do_cmd(5'b00010, 5'b0, 1'b0, 0, b1, b2, b3, rj, rj2, dn); void'(m_apply(5'b00010));
    probe(m_col, m_row, ic, st, cu);
    checks++; if (cu !== 1'b1 || dn !== 1'b1 || b3 !== 1'b0) begin
      errors++; $display("FAIL full_move got cursor=%b done=%b busy=%b exp 1 1 0", cu, dn, b3); end
    for (int c = 0; c < 64; c++) begin
      probe(c % 8, c / 8, ic, st, cu);
      checks++; if (st != m_board[c]) begin errors++; $display("FAIL full_board cell%0d got %0d exp %0d", c, st, m_board[c]); end
    end
  endtask

  initial begin
    m_reset();
    test_reset();
    test_reset_mid_wait();
    test_wrap();
    test_place();
    test_priority_drop();
    test_lookup();
    test_random_cmds();
    test_lookup();
    test_full_board();
    test_lookup();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
